// File: rtl/lfsr_pkg.sv
// Shared definitions for the x^10 + x^7 + 1 PRBS generator and checker.
package lfsr_pkg;
  localparam int LFSR_W    = 10;
  localparam int TAP_HI    = 9;
  localparam int TAP_LO    = 6;
  localparam int ERR_CNT_W = 16;

  typedef logic [LFSR_W-1:0]    sr_t;
  typedef logic [ERR_CNT_W-1:0] err_cnt_t;

  localparam sr_t TAP_MASK = sr_t'((1 << TAP_HI) | (1 << TAP_LO));

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
endpackage

// File: rtl/lfsr_checker_if.sv
// Bit stream in, lock/error status out; master drives the stream, slave is the checker.
interface lfsr_checker_if;
  import lfsr_pkg::*;

  logic       sh_en;
  logic       bit_in;
  logic       clr_cnt;
  logic       locked;
  logic       err_pulse;
  err_cnt_t   err_count;
  logic [1:0] sync_state;

  modport master (output sh_en, bit_in, clr_cnt,
                  input  locked, err_pulse, err_count, sync_state);
  modport slave  (input  sh_en, bit_in, clr_cnt,
                  output locked, err_pulse, err_count, sync_state);
endinterface

// File: rtl/lfsr_tap.sv
// Feedback bit of the shared polynomial; combinational, used by generator and checker.
module lfsr_tap
  import lfsr_pkg::*;
(
  input  sr_t  i_sr,
  output logic o_fb
);
  assign o_fb = ^(i_sr & TAP_MASK);
endmodule

// File: rtl/lfsr_checker.sv
// PRBS10 receive checker: hunts, verifies, then free-runs and counts bit errors.
// All outputs registered, one cycle after the sampling edge; nothing advances while sh_en is low.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT  = 16,
  parameter int WINDOW    = 64,
  parameter int ERR_LIMIT = 4
) (
  input logic           i_clk,
  input logic           i_rst_n,
  lfsr_checker_if.slave bus
);
  localparam logic [3:0]  FILL_LAST = 4'(LFSR_W - 1);
  localparam logic [7:0]  LOCK_N    = 8'(LOCK_CNT);
  localparam logic [9:0]  WIN_LAST  = 10'(WINDOW - 1);
  localparam logic [10:0] ERR_LIM   = 11'(ERR_LIMIT);

  sr_t        r_sr;
  logic [1:0] r_state;
  logic [3:0] r_fill;
  logic [7:0] r_match;
  logic [9:0] r_win;
  logic [9:0] r_werr;
  err_cnt_t   r_err_count;
  logic       r_err_pulse;

  logic        w_pred;
  logic        w_err;
  logic        w_sr_zero;
  logic        w_limit_hit;
  logic [7:0]  w_match_inc;
  logic [10:0] w_werr_inc;
  sr_t         w_sr_rx;

  lfsr_tap u_tap (.i_sr(r_sr), .o_fb(w_pred));

  assign w_err       = bus.bit_in ^ w_pred;
  assign w_sr_zero   = (r_sr == '0);
  assign w_sr_rx     = {r_sr[LFSR_W-2:0], bus.bit_in};
  assign w_match_inc = r_match + 8'd1;
  assign w_werr_inc  = {1'b0, r_werr} + {10'd0, w_err};
  assign w_limit_hit = w_err && (w_werr_inc >= ERR_LIM);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sr        <= '0;
      r_state     <= ST_HUNT;
      r_fill      <= '0;
      r_match     <= '0;
      r_win       <= '0;
      r_werr      <= '0;
      r_err_count <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (bus.sh_en) begin
        if (bus.clr_cnt)
          r_err_count <= '0;
        else if (r_state == ST_LOCKED && w_err && r_err_count != '1)
          r_err_count <= r_err_count + err_cnt_t'(1);

        case (r_state)
          ST_HUNT: begin
            r_sr   <= w_sr_rx;
            r_fill <= r_fill + 4'd1;
            if (r_fill == FILL_LAST) begin
              r_state <= ST_VERIFY;
              r_match <= '0;
            end
          end
          ST_VERIFY: begin
            r_sr <= w_sr_rx;
            // An all-zero register predicts zero forever, so it must never build lock.
            if (!w_err && !w_sr_zero) begin
              r_match <= w_match_inc;
              if (w_match_inc == LOCK_N) begin
                r_state <= ST_LOCKED;
                r_win   <= '0;
                r_werr  <= '0;
              end
            end else begin
              r_match <= '0;
            end
          end
          ST_LOCKED: begin
            r_err_pulse <= w_err;
            if (w_limit_hit) begin
              r_state <= ST_HUNT;
              r_fill  <= '0;
            end else begin
              r_sr <= {r_sr[LFSR_W-2:0], w_pred};
              if (r_win == WIN_LAST) begin
                r_win  <= '0;
                r_werr <= '0;
              end else begin
                r_win  <= r_win + 10'd1;
                r_werr <= w_werr_inc[9:0];
              end
            end
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

  // LOCKED is the only encoding with bit 1 set, so locked comes straight from the state flop.
  assign bus.locked     = r_state[1];
  assign bus.sync_state = r_state;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.err_count  = r_err_count;
endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised bench for lfsr_checker: two instances (default and large error limit) against a sequence-level model.
module tb_lfsr_checker;
  import lfsr_pkg::*;

  localparam int LK = 16;
  localparam int W0 = 64;
  localparam int L0 = 4;
  localparam int W1 = 1024;
  localparam int L1 = 1024;

  logic clk = 1'b0;
  logic rst_n0;
  logic rst_n1;
  always #5 clk = ~clk;

  lfsr_checker_if if0 ();
  lfsr_checker_if if1 ();

  lfsr_checker #(.LOCK_CNT(LK), .WINDOW(W0), .ERR_LIMIT(L0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n0), .bus(if0));
  lfsr_checker #(.LOCK_CNT(LK), .WINDOW(W1), .ERR_LIMIT(L1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n1), .bus(if1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the stream obeys s[n] = s[n-10] ^ s[n-7]; hist[k][0] is the newest bit.
  int         m_state [2];
  int         m_fill  [2];
  int         m_match [2];
  int         m_win   [2];
  int         m_werr  [2];
  int         m_errs  [2];
  bit         m_pulse [2];
  bit         m_hist  [2][10];

  logic [9:0]  g       [2];
  logic        o_lk    [2];
  logic        o_pl    [2];
  logic [15:0] o_cnt   [2];
  logic [1:0]  o_st    [2];
  int          pulse_cnt [2];
  bit          emask   [128];

  function automatic int wlen(int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic int elim(int k);
    return (k == 0) ? L0 : L1;
  endfunction

  function automatic void model_reset(int k);
    m_state[k] = 0; m_fill[k] = 0; m_match[k] = 0;
    m_win[k] = 0; m_werr[k] = 0; m_errs[k] = 0; m_pulse[k] = 0;
    for (int i = 0; i < 10; i++) m_hist[k][i] = 0;
  endfunction

  function automatic void model_push(int k, bit v);
    for (int i = 9; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
    m_hist[k][0] = v;
  endfunction

  function automatic void model_step(int k, bit en, bit b, bit clr);
    bit p, zero, err;
    int we;
    m_pulse[k] = 0;
    if (!en) return;
    if (clr) m_errs[k] = 0;
    p    = m_hist[k][9] ^ m_hist[k][6];
    zero = 1;
    for (int i = 0; i < 10; i++) if (m_hist[k][i]) zero = 0;
    err  = (b != p);
    case (m_state[k])
      0: begin
        model_push(k, b);
        m_fill[k]++;
        if (m_fill[k] == 10) begin m_state[k] = 1; m_match[k] = 0; end
      end
      1: begin
        if (!err && !zero) m_match[k]++; else m_match[k] = 0;
        model_push(k, b);
        if (m_match[k] == LK) begin m_state[k] = 2; m_win[k] = 0; m_werr[k] = 0; end
      end
      default: begin
        we = m_werr[k] + (err ? 1 : 0);
        if (err) begin
          m_pulse[k] = 1;
          if (!clr && m_errs[k] < 65535) m_errs[k]++;
        end
        if (we >= elim(k)) begin
          m_state[k] = 0;
          m_fill[k]  = 0;
        end else begin
          model_push(k, p);
          m_win[k]++;
          if (m_win[k] == wlen(k)) begin m_win[k] = 0; m_werr[k] = 0; end
          else m_werr[k] = we;
        end
      end
    endcase
  endfunction

  function automatic bit gen_next(int k);
    bit fb;
    fb   = g[k][9] ^ g[k][6];
    g[k] = {g[k][8:0], fb};
    return fb;
  endfunction

  task automatic cyc(input int k, input bit rst_n, input bit en, input bit b, input bit clr);
    if (k == 0) begin
      rst_n0 = rst_n; if0.sh_en = en; if0.bit_in = b; if0.clr_cnt = clr;
    end else begin
      rst_n1 = rst_n; if1.sh_en = en; if1.bit_in = b; if1.clr_cnt = clr;
    end
    @(posedge clk);
    if (!rst_n) model_reset(k); else model_step(k, en, b, clr);
    #1;
    if (k == 0) begin
      o_lk[0] = if0.locked; o_pl[0] = if0.err_pulse; o_cnt[0] = if0.err_count; o_st[0] = if0.sync_state;
    end else begin
      o_lk[1] = if1.locked; o_pl[1] = if1.err_pulse; o_cnt[1] = if1.err_count; o_st[1] = if1.sync_state;
    end
    if (o_pl[k] === 1'b1) pulse_cnt[k]++;
    chk(k == 0 ? "d0_locked" : "d1_locked", 32'(o_lk[k]),  32'(m_state[k] == 2));
    chk(k == 0 ? "d0_pulse"  : "d1_pulse",  32'(o_pl[k]),  32'(m_pulse[k]));
    chk(k == 0 ? "d0_count"  : "d1_count",  32'(o_cnt[k]), 32'(m_errs[k]));
    chk(k == 0 ? "d0_state"  : "d1_state",  32'(o_st[k]),  32'(m_state[k]));
  endtask

  task automatic send(input int k, input bit en, input bit err, input bit clr);
    bit b;
    if (en) b = gen_next(k) ^ err;
    else    b = 1'($urandom);
    cyc(k, 1'b1, en, b, clr);
  endtask

  task automatic idle_gap(input int k, input int gap_max);
    int n;
    n = $urandom_range(gap_max, 0);
    for (int i = 0; i < n; i++) send(k, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic align_window0();
    for (int i = 0; i < W0 && m_win[0] != 0; i++) send(0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pick_errs(input int lo, input int hi, input int n);
    int c;
    int r;
    c = 0;
    while (c < n) begin
      r = $urandom_range(hi, lo);
      if (!emask[r]) begin emask[r] = 1; c++; end
    end
  endtask

  task automatic clear_mask();
    for (int i = 0; i < 128; i++) emask[i] = 0;
  endtask

  task automatic lock_26(input int k, input int gap_max, input string tag);
    for (int n = 1; n <= 26; n++) begin
      idle_gap(k, gap_max);
      send(k, 1'b1, 1'b0, 1'b0);
      if (n == 25) chk({tag, "_b25"}, 32'(o_lk[k]), 32'd0);
    end
    chk({tag, "_b26"}, 32'(o_lk[k]), 32'd1);
  endtask

  task automatic main0();
    int rpos, nerr, mx;
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_locked", 32'(o_lk[0]), 32'd0);
    chk("rst_state",  32'(o_st[0]), 32'd0);
    chk("rst_count",  32'(o_cnt[0]), 32'd0);
    chk("rst_pulse",  32'(o_pl[0]), 32'd0);

    g[0] = 10'h26E;
    lock_26(0, 0, "lock");
    chk("lock_state", 32'(o_st[0]), 32'd2);

    pulse_cnt[0] = 0;
    for (int n = 0; n < 2000; n++) begin idle_gap(0, 2); send(0, 1'b1, 1'b0, 1'b0); end
    chk("clean_pulses", 32'(pulse_cnt[0]), 32'd0);
    chk("clean_count",  32'(o_cnt[0]), 32'd0);

    pulse_cnt[0] = 0;
    rpos = $urandom_range(50, 0);
    for (int n = 0; n < 100; n++) send(0, 1'b1, n == rpos, 1'b0);
    chk("single_pulses", 32'(pulse_cnt[0]), 32'd1);
    chk("single_count",  32'(o_cnt[0]), 32'd1);
    chk("single_lock",   32'(o_lk[0]), 32'd1);

    send(0, 1'b1, 1'b0, 1'b1);
    chk("clr_count", 32'(o_cnt[0]), 32'd0);

    align_window0();
    clear_mask();
    pick_errs(0, 39, 4);
    nerr = 0;
    for (int n = 0; n < 40; n++) begin
      send(0, 1'b1, emask[n], 1'b0);
      if (emask[n]) begin
        nerr++;
        if (nerr == 4) begin
          chk("loss_lock",  32'(o_lk[0]), 32'd0);
          chk("loss_state", 32'(o_st[0]), 32'd0);
          chk("loss_count", 32'(o_cnt[0]), 32'd4);
          chk("loss_pulse", 32'(o_pl[0]), 32'd1);
          break;
        end
        chk("pre_loss_lock", 32'(o_lk[0]), 32'd1);
      end
    end
    lock_26(0, 2, "relock");

    send(0, 1'b1, 1'b0, 1'b1);
    align_window0();
    clear_mask();
    pick_errs(0, 62, 2);
    emask[63] = 1;
    pick_errs(64, 127, 3);
    for (int n = 0; n < 128; n++) send(0, 1'b1, emask[n], 1'b0);
    chk("win_lock",  32'(o_lk[0]), 32'd1);
    chk("win_count", 32'(o_cnt[0]), 32'd6);

    clear_mask();
    pick_errs(0, 62, 3);
    for (int n = 0; n < 63; n++) send(0, 1'b1, emask[n], 1'b0);
    chk("win_last_pre", 32'(o_lk[0]), 32'd1);
    send(0, 1'b1, 1'b1, 1'b0);
    chk("win_last_loss",  32'(o_lk[0]), 32'd0);
    chk("win_last_count", 32'(o_cnt[0]), 32'd10);

    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
    mx = 0;
    for (int n = 0; n < 500; n++) begin
      cyc(0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (o_lk[0] !== 1'b0) mx = 1;
    end
    chk("zero_nolock", 32'(mx), 32'd0);
    chk("zero_state",  32'(o_st[0]), 32'd1);

    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
    g[0] = 10'($urandom_range(1023, 1));
    for (int n = 1; n <= 26; n++) begin
      send(0, 1'b0, 1'b0, 1'b0);
      send(0, 1'b0, 1'b0, 1'b0);
      send(0, 1'b1, 1'b0, 1'b0);
      if (n == 25) chk("gap_b25", 32'(o_lk[0]), 32'd0);
    end
    chk("gap_b26", 32'(o_lk[0]), 32'd1);
    send(0, 1'b0, 1'b0, 1'b0);
    chk("gap_hold_lock", 32'(o_lk[0]), 32'd1);

    send(0, 1'b1, 1'b1, 1'b0);
    chk("err_count1", 32'(o_cnt[0]), 32'd1);
    send(0, 1'b1, 1'b1, 1'b1);
    chk("clr_err_count", 32'(o_cnt[0]), 32'd0);
    chk("clr_err_pulse", 32'(o_pl[0]), 32'd1);
    send(0, 1'b1, 1'b1, 1'b0);
    send(0, 1'b1, 1'b1, 1'b0);
    chk("clr_then_loss", 32'(o_lk[0]), 32'd0);
    for (int n = 0; n < 15; n++) send(0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_state", 32'(o_st[0]), 32'd1);
    chk("pre_rst_count", 32'(o_cnt[0]), 32'd2);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("midrst_state", 32'(o_st[0]), 32'd0);
    chk("midrst_count", 32'(o_cnt[0]), 32'd0);
    chk("midrst_lock",  32'(o_lk[0]), 32'd0);
    chk("midrst_pulse", 32'(o_pl[0]), 32'd0);
  endtask

  task automatic sat1();
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b0);
    g[1] = 10'($urandom_range(1023, 1));
    lock_26(1, 0, "sat_lock");
    // 1023 errors plus one clean bit per 1024-bit window keeps the big instance locked.
    for (int w = 0; w < 65; w++)
      for (int p = 0; p < W1; p++) send(1, 1'b1, p != W1 - 1, 1'b0);
    chk("sat_count", 32'(o_cnt[1]), 32'hFFFF);
    chk("sat_lock",  32'(o_lk[1]), 32'd1);
    for (int n = 0; n < 50; n++) send(1, 1'b1, 1'b1, 1'b0);
    chk("sat_hold",  32'(o_cnt[1]), 32'hFFFF);
  endtask

  initial begin
    pulse_cnt[0] = 0;
    pulse_cnt[1] = 0;
    model_reset(0);
    model_reset(1);
    fork
      main0();
      sat1();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
